// File: rtl/f1_start_ctrl_if.sv
// Start-light controller bundle: driver/sequencer inputs and light/timing outputs.
interface f1_start_ctrl_if;
  logic        trigger;
  logic        react;
  logic [7:0]  data_out;
  logic [15:0] react_time;
  logic        valid;
  logic        false_start;

  // The stimulus/sequencer side drives trigger and react.
  modport master (
    output trigger,
    output react,
    input  data_out,
    input  react_time,
    input  valid,
    input  false_start
  );

  // The controller side consumes trigger and react.
  modport slave (
    input  trigger,
    input  react,
    output data_out,
    output react_time,
    output valid,
    output false_start
  );
endinterface

// File: rtl/f1_start_ctrl.sv
// F1-style start-light controller and reaction timer.
// The light bar fills one lamp per step, holds for a pseudo-random
// number of steps, goes dark, then times the driver's reaction.
// Pressing before lights-out is reported as a false start.
module f1_start_ctrl #(
  parameter int unsigned TICK_DIV = 4,
  parameter logic [6:0]  SEED     = 7'h01
) (
  input logic            clk,
  input logic            rst,
  f1_start_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LIGHTS = 3'd1,
    HOLD   = 3'd2,
    TIMING = 3'd3,
    DONE   = 3'd4
  } state_e;

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

  // x^7 + x^6 + 1 Fibonacci step; maximal length, so a non-zero seed never reaches zero.
  function automatic logic [6:0] lfsr_next(input logic [6:0] cur);
    lfsr_next = {cur[5:0], cur[6] ^ cur[5]};
  endfunction

  state_e      state_q, state_d;
  logic [15:0] tick_q, tick_d;
  logic [6:0]  lfsr_q, lfsr_d;
  logic [6:0]  delay_q, delay_d;
  logic [15:0] rt_q, rt_d;
  logic [7:0]  data_out_q, data_out_d;
  logic [15:0] react_time_q, react_time_d;
  logic        valid_q, valid_d;
  logic        false_start_q, false_start_d;
  logic        step_s;

  assign step_s          = (tick_q == TICK_LAST);
  assign bus.data_out    = data_out_q;
  assign bus.react_time  = react_time_q;
  assign bus.valid       = valid_q;
  assign bus.false_start = false_start_q;

  // State and output registers; reset drops everything back to a dark, idle bar.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      tick_q        <= 16'd0;
      lfsr_q        <= SEED;
      delay_q       <= 7'd0;
      rt_q          <= 16'd0;
      data_out_q    <= 8'h00;
      react_time_q  <= 16'd0;
      valid_q       <= 1'b0;
      false_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tick_q        <= tick_d;
      lfsr_q        <= lfsr_d;
      delay_q       <= delay_d;
      rt_q          <= rt_d;
      data_out_q    <= data_out_d;
      react_time_q  <= react_time_d;
      valid_q       <= valid_d;
      false_start_q <= false_start_d;
    end
  end

  // Next-state and next-output logic for the start sequence.
  always_comb begin
    state_d       = state_q;
    tick_d        = 16'd0;
    lfsr_d        = lfsr_next(lfsr_q);
    delay_d       = delay_q;
    rt_d          = rt_q;
    data_out_d    = data_out_q;
    react_time_d  = react_time_q;
    valid_d       = valid_q;
    false_start_d = false_start_q;

    case (state_q)
      IDLE: begin
        data_out_d = 8'h00;
        if (bus.trigger) begin
          state_d       = LIGHTS;
          data_out_d    = 8'h01;
          valid_d       = 1'b0;
          false_start_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end

      LIGHTS: begin
        if (bus.react) begin
          // Jumped the lights: abort and flag, keep the last good time.
          state_d       = DONE;
          data_out_d    = 8'h00;
          valid_d       = 1'b0;
          false_start_d = 1'b1;
        end else if (step_s) begin
          if (data_out_q == 8'hFF) begin
            // Full bar for one step already; freeze it for a random hold.
            state_d = HOLD;
            delay_d = lfsr_q;
          end else begin
            data_out_d = {data_out_q[6:0], 1'b1};
          end
        end else begin
          tick_d = tick_q + 16'd1;
        end
      end

      HOLD: begin
        if (bus.react) begin
          // A press on the very last hold cycle still counts as early.
          state_d       = DONE;
          data_out_d    = 8'h00;
          valid_d       = 1'b0;
          false_start_d = 1'b1;
        end else if (step_s) begin
          if (delay_q <= 7'd1) begin
            state_d    = TIMING;
            data_out_d = 8'h00;
            rt_d       = 16'd0;
          end else begin
            delay_d = delay_q - 7'd1;
          end
        end else begin
          tick_d = tick_q + 16'd1;
        end
      end

      TIMING: begin
        if (bus.react) begin
          state_d      = DONE;
          react_time_d = rt_q;
          valid_d      = 1'b1;
        end else if (rt_q != 16'hFFFF) begin
          rt_d = rt_q + 16'd1;
        end else begin
          rt_d = rt_q;
        end
      end

      DONE: begin
        // Trigger beats react here; react is then judged in LIGHTS.
        if (bus.trigger) begin
          state_d       = LIGHTS;
          data_out_d    = 8'h01;
          valid_d       = 1'b0;
          false_start_d = 1'b0;
        end else begin
          state_d = DONE;
        end
      end

      default: begin
        state_d    = IDLE;
        data_out_d = 8'h00;
      end
    endcase
  end

endmodule

// File: tb/tb_f1_start_ctrl.sv
// Directed bench for f1_start_ctrl with TICK_DIV=4 and a cycle-accurate
// LFSR model to predict the random hold length.
module tb_f1_start_ctrl;

  localparam logic [6:0] SEED = 7'h01;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  logic [6:0] lfsr_m;
  int   d;

  f1_start_ctrl_if bus_if ();

  f1_start_ctrl #(
    .TICK_DIV (4),
    .SEED     (SEED)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: sample point is 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rst) lfsr_m = SEED;
    else     lfsr_m = {lfsr_m[5:0], lfsr_m[6] ^ lfsr_m[5]};
  endtask

  // Pulse trigger for one edge; afterwards we sit in cycle 1 of the sequence.
  task automatic start_seq(input string tag);
    bus_if.trigger = 1'b1;
    tick();
    bus_if.trigger = 1'b0;
    check_eq({tag, "_bar01"}, 32'(bus_if.data_out), 32'h01);
    check_eq({tag, "_valid0"}, 32'(bus_if.valid), 32'h0);
    check_eq({tag, "_fs0"}, 32'(bus_if.false_start), 32'h0);
  endtask

  // Cycle 1 -> cycle 33 (first HOLD cycle); returns the hold length in steps.
  task automatic lights_to_hold(input string tag, output int dd);
    logic [15:0] therm;
    for (int c = 2; c <= 32; c++) begin
      tick();
      therm = (16'd1 << ((c - 1) / 4 + 1)) - 16'd1;
      check_eq({tag, "_bar"}, 32'(bus_if.data_out), 32'(therm[7:0]));
    end
    dd = int'(lfsr_m);
    tick();
    check_eq({tag, "_hold_ff"}, 32'(bus_if.data_out), 32'hFF);
  endtask

  // Cycle 33 -> last HOLD cycle (32 + 4*dd), bar stays full.
  task automatic run_hold(input string tag, input int dd);
    for (int c = 34; c <= 32 + 4 * dd; c++) begin
      tick();
      check_eq({tag, "_hold"}, 32'(bus_if.data_out), 32'hFF);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus_if.trigger = 1'b0;
    bus_if.react = 1'b0;
    lfsr_m = SEED;

    // Reset state
    tick();
    check_eq("rst_bar", 32'(bus_if.data_out), 32'h0);
    check_eq("rst_rt", 32'(bus_if.react_time), 32'h0);
    check_eq("rst_valid", 32'(bus_if.valid), 32'h0);
    check_eq("rst_fs", 32'(bus_if.false_start), 32'h0);
    rst = 1'b0;
    lfsr_m = SEED;

    // react in IDLE is ignored
    bus_if.react = 1'b1;
    tick();
    bus_if.react = 1'b0;
    check_eq("idle_react_bar", 32'(bus_if.data_out), 32'h0);
    check_eq("idle_react_fs", 32'(bus_if.false_start), 32'h0);
    tick();

    // Normal run: react 10 cycles after lights-out
    start_seq("norm");
    lights_to_hold("norm", d);
    run_hold("norm", d);
    tick();
    check_eq("norm_lights_out", 32'(bus_if.data_out), 32'h0);
    check_eq("norm_timing_valid", 32'(bus_if.valid), 32'h0);
    for (int i = 0; i < 10; i++) tick();
    bus_if.react = 1'b1;
    tick();
    bus_if.react = 1'b0;
    check_eq("norm_rt", 32'(bus_if.react_time), 32'd10);
    check_eq("norm_valid", 32'(bus_if.valid), 32'h1);
    check_eq("norm_fs", 32'(bus_if.false_start), 32'h0);
    // DONE holds outputs, react ignored
    tick();
    bus_if.react = 1'b1;
    tick();
    bus_if.react = 1'b0;
    tick();
    check_eq("done_hold_rt", 32'(bus_if.react_time), 32'd10);
    check_eq("done_hold_valid", 32'(bus_if.valid), 32'h1);

    // False start at cycle 12, in LIGHTS
    start_seq("fs");
    for (int i = 0; i < 11; i++) tick();
    bus_if.react = 1'b1;
    tick();
    bus_if.react = 1'b0;
    check_eq("fs_flag", 32'(bus_if.false_start), 32'h1);
    check_eq("fs_valid", 32'(bus_if.valid), 32'h0);
    check_eq("fs_bar", 32'(bus_if.data_out), 32'h0);
    check_eq("fs_rt_kept", 32'(bus_if.react_time), 32'd10);

    // Retrigger clears flag; false start on last HOLD cycle
    start_seq("refs");
    lights_to_hold("last", d);
    run_hold("last", d);
    bus_if.react = 1'b1;
    tick();
    bus_if.react = 1'b0;
    check_eq("last_hold_fs", 32'(bus_if.false_start), 32'h1);
    check_eq("last_hold_bar", 32'(bus_if.data_out), 32'h0);
    check_eq("last_hold_valid", 32'(bus_if.valid), 32'h0);

    // Trigger held high: one sequence, restart only from DONE
    bus_if.trigger = 1'b1;
    tick();
    check_eq("hold_trig_bar01", 32'(bus_if.data_out), 32'h01);
    check_eq("hold_trig_fs0", 32'(bus_if.false_start), 32'h0);
    for (int i = 0; i < 12; i++) tick();
    check_eq("hold_trig_bar0f", 32'(bus_if.data_out), 32'h0F);
    bus_if.react = 1'b1;
    tick();
    bus_if.react = 1'b0;
    check_eq("hold_trig_fs", 32'(bus_if.false_start), 32'h1);
    check_eq("hold_trig_dark", 32'(bus_if.data_out), 32'h0);
    tick();
    bus_if.trigger = 1'b0;
    check_eq("hold_trig_restart", 32'(bus_if.data_out), 32'h01);
    check_eq("hold_trig_fs_clr", 32'(bus_if.false_start), 32'h0);

    // Async reset mid-HOLD
    lights_to_hold("arst", d);
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_bar", 32'(bus_if.data_out), 32'h0);
    check_eq("arst_rt", 32'(bus_if.react_time), 32'h0);
    check_eq("arst_valid", 32'(bus_if.valid), 32'h0);
    check_eq("arst_fs", 32'(bus_if.false_start), 32'h0);
    tick();
    rst = 1'b0;
    lfsr_m = SEED;
    tick();
    check_eq("arst_idle", 32'(bus_if.data_out), 32'h0);
    tick();
    check_eq("arst_idle2", 32'(bus_if.data_out), 32'h0);

    // Saturation of the reaction counter
    start_seq("sat");
    lights_to_hold("sat", d);
    run_hold("sat", d);
    tick();
    check_eq("sat_lights_out", 32'(bus_if.data_out), 32'h0);
    for (int i = 0; i < 70000; i++) tick();
    check_eq("sat_no_valid", 32'(bus_if.valid), 32'h0);
    bus_if.react = 1'b1;
    tick();
    bus_if.react = 1'b0;
    check_eq("sat_rt", 32'(bus_if.react_time), 32'hFFFF);
    check_eq("sat_valid", 32'(bus_if.valid), 32'h1);

    // React on first TIMING cycle gives zero
    start_seq("zero");
    lights_to_hold("zero", d);
    run_hold("zero", d);
    tick();
    check_eq("zero_lights_out", 32'(bus_if.data_out), 32'h0);
    bus_if.react = 1'b1;
    tick();
    bus_if.react = 1'b0;
    check_eq("zero_rt", 32'(bus_if.react_time), 32'h0);
    check_eq("zero_valid", 32'(bus_if.valid), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
